// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or
// unsigned, quotient and remainder returned together over a valid/ready pair.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] x_raw_q, x_raw_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    x_raw_d     = x_raw_q;
    quo_d       = quo_q;
    rmd_d       = rmd_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    res_valid_d = res_valid_q;
    // The dividend register doubles as the quotient shift register.
    shifted     = {rem_q, dvd_q[WIDTH-1]};
    trial       = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (div_valid) begin
          state_d = CALC;
          cnt_d   = '0;
          rem_d   = '0;
          dvd_d   = negate_if(x, div_signed & x[WIDTH-1]);
          dvs_d   = negate_if(y, div_signed & y[WIDTH-1]);
          qneg_d  = div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
          rneg_d  = div_signed & x[WIDTH-1];
          dz_d    = (y == '0);
          x_raw_d = x;
        end
      end
      CALC: begin
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero returns all ones and the untouched dividend.
        if (dz_q) begin
          quo_d = '1;
          rmd_d = x_raw_q;
        end else begin
          quo_d = negate_if(dvd_q, qneg_q);
          rmd_d = negate_if(rem_q, rneg_q);
        end
        state_d = DONE;
      end
      DONE: begin
        res_valid_d = 1'b1;
        if (res_valid_q && res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      x_raw_q     <= '0;
      quo_q       <= '0;
      rmd_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      x_raw_q     <= x_raw_d;
      quo_q       <= quo_d;
      rmd_q       <= rmd_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign div_ready = (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule
